// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: pipeline-side hazard inputs and control/counter outputs of the hazard unit.
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic [15:0]       if_id_inst;
    logic              if_id_valid;
    logic              id_ex_memread;
    logic [REG_AW-1:0] id_ex_rd;
    logic              br_taken;
    logic              mem_busy;
    logic              stall;
    logic              id_flush;
    logic              if_flush;
    logic              freeze;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output if_id_inst, if_id_valid, id_ex_memread, id_ex_rd, br_taken, mem_busy,
        input  stall, id_flush, if_flush, freeze, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  if_id_inst, if_id_valid, id_ex_memread, id_ex_rd, br_taken, mem_busy,
        output stall, id_flush, if_flush, freeze, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use and flag hazard detection, branch squash, memory-wait freeze FSM
// with timeout error, and saturating stall/flush performance counters.
module hazard_ctrl_unit #(
    parameter int          REG_AW        = 4,
    parameter int          FLAG_DEPTH    = 2,
    parameter logic [15:0] FLAG_OPC_MASK = 16'h0077,
    parameter int          CNT_W         = 16,
    parameter int          MEM_TIMEOUT   = 15
) (
    input logic               clk,
    input logic               rst_n,
    hazard_ctrl_unit_if.slave bus
);
    localparam int WCW = (MEM_TIMEOUT > 15) ? $clog2(MEM_TIMEOUT + 1) : 4;

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t                r_state, w_next;
    logic [WCW-1:0]        r_wcnt;
    logic [FLAG_DEPTH-1:0] r_sb;
    logic [CNT_W-1:0]      r_stall_cnt, r_flush_cnt;
    logic [3:0]            w_opc;
    logic [REG_AW-1:0]     w_rs, w_rt;
    logic                  w_reading, w_load_use, w_flag_haz;
    logic                  w_freeze, w_stall, w_if_flush, w_sb_in;

    assign w_opc      = bus.if_id_inst[15:12];
    assign w_rs       = bus.if_id_inst[4 +: REG_AW];
    assign w_rt       = (w_opc[3:1] == 3'b100) ? bus.if_id_inst[8 +: REG_AW] : bus.if_id_inst[0 +: REG_AW];
    assign w_reading  = ~w_opc[3] | (w_opc[3:1] == 3'b100) | (w_opc[3:1] == 3'b110);
    assign w_load_use = bus.if_id_valid & w_reading & bus.id_ex_memread &
                        ((bus.id_ex_rd == w_rs) | (bus.id_ex_rd == w_rt));
    // Conditional branches (cond field != 111) wait for in-flight flag writers to retire
    assign w_flag_haz = bus.if_id_valid & (w_opc[3:1] == 3'b110) &
                        (bus.if_id_inst[11:9] != 3'b111) & (|r_sb);
    assign w_stall    = (w_load_use | w_flag_haz) & ~w_freeze & rst_n;
    assign w_if_flush = bus.br_taken & ~w_stall & ~w_freeze & rst_n;
    assign w_sb_in    = bus.if_id_valid & FLAG_OPC_MASK[w_opc] & ~w_stall;

    always_comb begin
        w_next   = r_state;
        w_freeze = bus.mem_busy;
        case (r_state)
            IDLE:    w_next = bus.mem_busy ? WAIT : IDLE;
            WAIT:    w_next = !bus.mem_busy ? IDLE : (r_wcnt == WCW'(MEM_TIMEOUT)) ? ERR : WAIT;
            default: begin
                w_next   = ERR;
                w_freeze = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= (r_state == WAIT && w_next == WAIT) ? r_wcnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb        <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!w_freeze) begin
            r_sb <= FLAG_DEPTH'({r_sb, w_sb_in});
            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_if_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.id_flush  = w_stall;
    assign bus.if_flush  = w_if_flush;
    assign bus.freeze    = w_freeze;
    assign bus.mem_err   = (r_state == ERR);
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed vector table for combinational hazards plus sequences for
// flag scoreboard, branch-vs-stall, freeze, counter saturation and memory timeout.
module tb_hazard_ctrl_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.REG_AW(4), .CNT_W(4)) bus ();

    hazard_ctrl_unit #(
        .REG_AW(4), .FLAG_DEPTH(2), .FLAG_OPC_MASK(16'h0077), .CNT_W(4), .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] inst;
        logic        valid;
        logic        memread;
        logic [3:0]  rd;
        logic        br;
        logic        busy;
        logic        e_stall;
        logic        e_iff;
        logic        e_frz;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic [15:0] inst, logic v, logic m, logic [3:0] rd,
                                logic br, logic busy, logic es, logic ei, logic ef);
        vec_t r;
        r.inst = inst; r.valid = v; r.memread = m; r.rd = rd; r.br = br; r.busy = busy;
        r.e_stall = es; r.e_iff = ei; r.e_frz = ef;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] inst, input logic v, input logic m,
                         input logic [3:0] rd, input logic br, input logic busy);
        bus.if_id_inst = inst; bus.if_id_valid = v; bus.id_ex_memread = m;
        bus.id_ex_rd = rd; bus.br_taken = br; bus.mem_busy = busy;
    endtask

    task automatic idle();
        drive(16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk(16'h0134, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(16'h0134, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(16'h0134, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(16'h0134, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(16'h0134, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(16'h8534, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(16'h8534, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(16'hA034, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(16'hD034, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(16'hE034, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(16'h0134, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[11] = mk(16'h0134, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(16'h0134, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[13] = mk(16'h9734, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset: hazard inputs present must not leak onto stall/flush; freeze follows mem_busy
        idle();
        repeat (2) step();
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("rst_flush_cnt", 32'(bus.flush_cnt), 32'h0);
        chk("rst_mem_err", 32'(bus.mem_err), 32'h0);
        chk("rst_freeze_idle", 32'(bus.freeze), 32'h0);
        drive(16'h0134, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
        #1;
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_if_flush", 32'(bus.if_flush), 32'h0);
        chk("rst_freeze_busy", 32'(bus.freeze), 32'h1);
        idle();
        #1;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].inst, vecs[i].valid, vecs[i].memread, vecs[i].rd, vecs[i].br, vecs[i].busy);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_id_flush", i), 32'(bus.id_flush), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_if_flush", i), 32'(bus.if_flush), 32'(vecs[i].e_iff));
            chk($sformatf("vec%0d_freeze", i), 32'(bus.freeze), 32'(vecs[i].e_frz));
            step();
            idle();
            repeat (3) step();
        end

        // Load-use for exactly one cycle
        do_reset();
        drive(16'h0134, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        #1;
        chk("lu_stall", 32'(bus.stall), 32'h1);
        chk("lu_id_flush", 32'(bus.id_flush), 32'h1);
        step();
        idle();
        #1;
        chk("lu_released", 32'(bus.stall), 32'h0);
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'h1);

        // Flag hazard: ADD then conditional branch stalls FLAG_DEPTH cycles
        drive(16'h0012, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("flag_add", 32'(bus.stall), 32'h0);
        step();
        drive(16'hC004, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("flag_c1", 32'(bus.stall), 32'h1);
        step();
        chk("flag_c2", 32'(bus.stall), 32'h1);
        step();
        chk("flag_rel", 32'(bus.stall), 32'h0);
        chk("flag_stall_cnt", 32'(bus.stall_cnt), 32'h3);
        step();
        drive(16'h0012, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        drive(16'hCE04, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("flag_uncond", 32'(bus.stall), 32'h0);
        step();
        idle();
        repeat (3) step();

        // Branch while stalled is held back, then flushes once the hazard clears
        drive(16'h0134, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        #1;
        chk("brst_stall", 32'(bus.stall), 32'h1);
        chk("brst_if_flush", 32'(bus.if_flush), 32'h0);
        step();
        drive(16'h0134, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
        #1;
        chk("br_stall", 32'(bus.stall), 32'h0);
        chk("br_if_flush", 32'(bus.if_flush), 32'h1);
        step();
        idle();
        #1;
        chk("br_flush_cnt", 32'(bus.flush_cnt), 32'h1);
        chk("br_stall_cnt", 32'(bus.stall_cnt), 32'h4);
        repeat (3) step();

        // Freeze holds the scoreboard: the flag writer loaded before mem_busy still blocks afterwards
        drive(16'h0134, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
        step();
        drive(16'h0134, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("frz%0d_freeze", c), 32'(bus.freeze), 32'h1);
            chk($sformatf("frz%0d_stall", c), 32'(bus.stall), 32'h0);
            step();
        end
        drive(16'hC004, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("frz_end_freeze", 32'(bus.freeze), 32'h0);
        chk("frz_sb_held1", 32'(bus.stall), 32'h1);
        step();
        chk("frz_sb_held2", 32'(bus.stall), 32'h1);
        step();
        chk("frz_sb_clear", 32'(bus.stall), 32'h0);
        chk("frz_mem_err", 32'(bus.mem_err), 32'h0);
        chk("frz_stall_cnt", 32'(bus.stall_cnt), 32'h6);
        idle();
        step();

        // Saturation of the 4-bit stall counter
        drive(16'h0134, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        repeat (20) step();
        chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'hF);
        idle();
        step();
        chk("sat_hold", 32'(bus.stall_cnt), 32'hF);
        chk("sat_flush_cnt", 32'(bus.flush_cnt), 32'h1);

        // Timeout: ERR on the 17th busy edge, sticky until reset
        bus.mem_busy = 1'b1;
        repeat (16) step();
        chk("to_pre_err", 32'(bus.mem_err), 32'h0);
        step();
        chk("to_err", 32'(bus.mem_err), 32'h1);
        repeat (3) step();
        drive(16'h0134, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        #1;
        chk("to_err_sticky", 32'(bus.mem_err), 32'h1);
        chk("to_err_freeze", 32'(bus.freeze), 32'h1);
        chk("to_err_stall", 32'(bus.stall), 32'h0);
        chk("to_err_if_flush", 32'(bus.if_flush), 32'h0);
        step();
        chk("to_err_hold", 32'(bus.mem_err), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("to_rst_mem_err", 32'(bus.mem_err), 32'h0);
        chk("to_rst_freeze", 32'(bus.freeze), 32'h0);
        chk("to_rst_stall", 32'(bus.stall), 32'h0);
        chk("to_rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("to_rst_flush_cnt", 32'(bus.flush_cnt), 32'h0);
        idle();
        #1;
        rst_n = 1'b1;
        step();
        chk("to_post_freeze", 32'(bus.freeze), 32'h0);
        chk("to_post_mem_err", 32'(bus.mem_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 4: register address width.
REQ-002 SHALL have parameter FLAG_DEPTH, default 2: number of stages between ID and flag write-back, range 1..4.
REQ-003 SHALL have parameter FLAG_OPC_MASK, 16 bits, default 16'h0077: bit n set means opcode n writes flags.
REQ-004 SHALL have parameter CNT_W, default 16: performance counter width.
REQ-005 SHALL have parameter MEM_TIMEOUT, default 15: maximum mem_busy cycles before error.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk input 1 bit (rising-edge clock); rst_n input 1 bit (async active-low reset).
REQ-007 SHALL have if_id_inst input 16 bits: instruction in ID.
REQ-008 SHALL have if_id_valid input 1 bit: ID holds a real instruction.
REQ-009 SHALL have id_ex_memread input 1 bit: EX instruction is a load.
REQ-010 SHALL have id_ex_rd input REG_AW bits: destination register of the EX load.
REQ-011 SHALL have br_taken input 1 bit: branch in ID resolved taken.
REQ-012 SHALL have mem_busy input 1 bit: data memory multi-cycle access in progress.
REQ-013 SHALL have stall output 1 bit: hold PC and IF/ID.
REQ-014 SHALL have id_flush output 1 bit: insert bubble into ID/EX.
REQ-015 SHALL have if_flush output 1 bit: squash IF/ID.
REQ-016 SHALL have freeze output 1 bit: hold every pipeline register, no bubble.
REQ-017 SHALL have mem_err output 1 bit: sticky memory-timeout flag.
REQ-018 SHALL have stall_cnt output CNT_W bits: count of stall cycles.
REQ-019 SHALL have flush_cnt output CNT_W bits: count of if_flush cycles.

Function
REQ-020 SHALL decode opc = if_id_inst[15:12], rs = [7:4], and rt = [11:8] when opc is 1000/1001, else [3:0]; the low REG_AW bits are compared.
REQ-021 SHALL treat as register-reading: opc[3]=0, opc 1000, opc 1001, opc 110x; all other opcodes SHALL raise no data stall.
REQ-022 SHALL raise load-use hazard = if_id_valid & reading & id_ex_memread & (id_ex_rd==rs | id_ex_rd==rt).
REQ-023 SHALL keep a FLAG_DEPTH-bit scoreboard shift register sb, which shifts toward the MSB each non-frozen cycle.
REQ-024 SHALL load sb[0] with if_id_valid & FLAG_OPC_MASK[opc] & ~stall; bits shifted out of sb[FLAG_DEPTH-1] are discarded.
REQ-025 SHALL raise flag hazard = if_id_valid & opc[3:1]==3'b110 & if_id_inst[11:9]!=3'b111 & (|sb).
REQ-026 SHALL set stall = id_flush = (load-use | flag hazard) & ~freeze, combinationally.
REQ-027 SHALL set if_flush = br_taken & ~stall & ~freeze; a stalled branch is not yet resolved, so stall has priority.
REQ-028 SHALL use a memory FSM with states IDLE, WAIT, and ERR.
REQ-029 SHALL go IDLE->WAIT on mem_busy, WAIT->IDLE on ~mem_busy, and WAIT->ERR when a 4-bit-min wait counter reaches MEM_TIMEOUT with mem_busy still high.
REQ-030 SHALL hold ERR until reset, with mem_err=1 in ERR.
REQ-031 SHALL set freeze = mem_busy in IDLE or WAIT, and freeze = 1 in ERR.
REQ-032 SHALL clear the wait counter on entry to IDLE and increment it each WAIT cycle.
REQ-033 SHALL leave sb and all other state unchanged while freeze=1.
REQ-034 SHALL increment stall_cnt on every cycle with stall=1, and flush_cnt on every cycle with if_flush=1.
REQ-035 SHALL saturate both counters at all ones, with no wrap.
REQ-036 SHALL give hazard outputs zero latency from their inputs; scoreboard effects are visible the cycle after the flag writer leaves ID.

Reset
REQ-037 SHALL, while rst_n=0, asynchronously force sb=0, FSM=IDLE, wait counter=0, stall_cnt=0, flush_cnt=0, and mem_err=0.
REQ-038 SHALL assert stall/id_flush/if_flush=0 during reset and reflect only mem_busy on freeze.
REQ-039 SHALL, on a reset mid-WAIT or in ERR, return to IDLE and clear mem_err with no residual freeze beyond mem_busy.

Verification
REQ-040 SHALL cover load-use: id_ex_memread=1, id_ex_rd=3, inst=16'h0134 (ADD, rs=3) -> stall=id_flush=1 for one cycle, stall_cnt=1.
REQ-041 SHALL cover the flag hazard: ADD (16'h0012) then conditional branch 16'hC004 on the next cycle -> stall for FLAG_DEPTH=2 cycles, released on the third; the unconditional form 16'hCE04 -> no stall.
REQ-042 SHALL cover a branch while stalled: br_taken=1 with a load-use hazard present -> if_flush=0; hazard cleared next cycle -> if_flush=1, flush_cnt=1.
REQ-043 SHALL cover the freeze: mem_busy=1 for 5 cycles with ADD in ID -> freeze=1, stall=0, sb unchanged, return to IDLE.
REQ-044 SHALL cover the timeout: mem_busy held 20 cycles with MEM_TIMEOUT=15 -> ERR with mem_err=1 persisting after mem_busy drops; rst_n pulse low -> mem_err=0, FSM IDLE.
REQ-045 SHALL cover saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=4'hF held.
